// File: rtl/datapath_sequencer.sv
// datapath_sequencer: steps DatapathRegALU through one instruction at a time.
// An instruction is latched in IDLE, its control word is driven for one EXEC
// cycle (plus one LD_WB cycle for loads), and completion is reported through
// done/retired. Every control output is registered so the datapath sees a
// glitch-free word for the whole cycle.
module datapath_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [3:0]  status,
    output logic        instr_ready,
    output logic [4:0]  DA,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic        W,
    output logic [63:0] K,
    output logic        BS,
    output logic [4:0]  FS,
    output logic        write,
    output logic        selEN,
    output logic [3:0]  flags,
    output logic [15:0] retired,
    output logic        done,
    output logic        illegal
);

    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;

    localparam logic [4:0] REG_ZERO = 5'd31;

    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_LSLI = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        LD_WB = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  da_q, da_d;
    logic [4:0]  sa_q, sa_d;
    logic [4:0]  sb_q, sb_d;
    logic        w_q, w_d;
    logic [63:0] k_q, k_d;
    logic        bs_q, bs_d;
    logic [4:0]  fs_q, fs_d;
    logic        write_q, write_d;
    logic        sel_en_q, sel_en_d;
    logic        ready_q, ready_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] retired_q, retired_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;

    logic [3:0]  op_in;
    logic [4:0]  rd_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [12:0] imm_in;
    logic [63:0] imm_ext;

    assign op_in   = instr[31:28];
    assign rd_in   = instr[27:23];
    assign rs1_in  = instr[22:18];
    assign rs2_in  = instr[17:13];
    assign imm_in  = instr[12:0];
    assign imm_ext = {51'd0, imm_in};

    // Next-state and next control word: the word for a cycle is decided one
    // edge early so that it can be driven straight from flops.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        da_d      = 5'd0;
        sa_d      = 5'd0;
        sb_d      = 5'd0;
        w_d       = 1'b0;
        k_d       = 64'd0;
        bs_d      = 1'b0;
        fs_d      = FS_OR;
        write_d   = 1'b0;
        sel_en_d  = 1'b0;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        flags_d   = flags_q;
        retired_d = retired_q;
        illegal_d = illegal_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (instr_valid && ready_q) begin
                    state_d   = EXEC;
                    op_d      = op_in;
                    rd_d      = rd_in;
                    ready_d   = 1'b0;
                    done_d    = (op_in != OP_LD);
                    illegal_d = illegal_q | op_in[3];
                    case (op_in)
                        OP_LDI: begin
                            da_d = rd_in;
                            sa_d = REG_ZERO;
                            bs_d = 1'b1;
                            k_d  = imm_ext;
                            fs_d = FS_OR;
                            w_d  = 1'b1;
                        end
                        OP_ADD, OP_XOR: begin
                            da_d = rd_in;
                            sa_d = rs1_in;
                            sb_d = rs2_in;
                            fs_d = (op_in == OP_ADD) ? FS_ADD : FS_XOR;
                            w_d  = 1'b1;
                        end
                        OP_LSLI, OP_ADDI: begin
                            da_d = rd_in;
                            sa_d = rs1_in;
                            bs_d = 1'b1;
                            k_d  = imm_ext;
                            fs_d = (op_in == OP_LSLI) ? FS_LSL : FS_ADD;
                            w_d  = 1'b1;
                        end
                        OP_ST: begin
                            sa_d    = rs1_in;
                            sb_d    = rs2_in;
                            bs_d    = 1'b1;
                            write_d = 1'b1;
                        end
                        OP_LD: begin
                            sa_d = rs1_in;
                            bs_d = 1'b1;
                        end
                        default: begin
                            // NOP and undefined opcodes keep the idle word.
                        end
                    endcase
                end
            end

            EXEC: begin
                if (op_q == OP_LD) begin
                    // Address path stays put while memory data is written back.
                    state_d  = LD_WB;
                    sa_d     = sa_q;
                    bs_d     = bs_q;
                    k_d      = k_q;
                    fs_d     = fs_q;
                    da_d     = rd_q;
                    w_d      = 1'b1;
                    sel_en_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    retired_d = retired_q + 16'd1;
                    if (op_q inside {OP_LDI, OP_ADD, OP_XOR, OP_LSLI, OP_ADDI}) begin
                        flags_d = status;
                    end
                end
            end

            LD_WB: begin
                state_d   = IDLE;
                ready_d   = 1'b1;
                retired_d = retired_q + 16'd1;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, latched instruction fields and the registered control word;
    // reset drops straight back to the idle word so no W/write pulse escapes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 4'd0;
            rd_q      <= 5'd0;
            da_q      <= 5'd0;
            sa_q      <= 5'd0;
            sb_q      <= 5'd0;
            w_q       <= 1'b0;
            k_q       <= 64'd0;
            bs_q      <= 1'b0;
            fs_q      <= FS_OR;
            write_q   <= 1'b0;
            sel_en_q  <= 1'b0;
            ready_q   <= 1'b1;
            flags_q   <= 4'd0;
            retired_q <= 16'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            da_q      <= da_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            w_q       <= w_d;
            k_q       <= k_d;
            bs_q      <= bs_d;
            fs_q      <= fs_d;
            write_q   <= write_d;
            sel_en_q  <= sel_en_d;
            ready_q   <= ready_d;
            flags_q   <= flags_d;
            retired_q <= retired_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = ready_q;
    assign DA          = da_q;
    assign SA          = sa_q;
    assign SB          = sb_q;
    assign W           = w_q;
    assign K           = k_q;
    assign BS          = bs_q;
    assign FS          = fs_q;
    assign write       = write_q;
    assign selEN       = sel_en_q;
    assign flags       = flags_q;
    assign retired     = retired_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: drives datapath_sequencer against a behavioural
// register-file/ALU/memory stand-in and an instruction-level reference model.
module tb_datapath_sequencer;

    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;

    typedef struct packed {
        logic [4:0]  da;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        w;
        logic [63:0] k;
        logic        bs;
        logic [4:0]  fs;
        logic        wr;
        logic        sel;
    } word_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        instr_ready;
    logic [4:0]  DA, SA, SB;
    logic        W;
    logic [63:0] K;
    logic        BS;
    logic [4:0]  FS;
    logic        write;
    logic        selEN;
    logic [3:0]  flags;
    logic [15:0] retired;
    logic        done;
    logic        illegal;

    int checks = 0;
    int passes = 0;

    logic [15:0] expRetired = 16'd0;
    logic [3:0]  expFlags   = 4'd0;
    logic        expIllegal = 1'b0;

    logic [63:0] regs  [32]  = '{default: 64'd0};
    logic [63:0] dpMem [256] = '{default: 64'd0};
    logic [63:0] archR [32]  = '{default: 64'd0};
    logic [63:0] archM [256] = '{default: 64'd0};

    logic [63:0] aBus, bBus, fRes, dBus, storeData;
    word_t       obsW;

    datapath_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .status      (status),
        .instr_ready (instr_ready),
        .DA          (DA),
        .SA          (SA),
        .SB          (SB),
        .W           (W),
        .K           (K),
        .BS          (BS),
        .FS          (FS),
        .write       (write),
        .selEN       (selEN),
        .flags       (flags),
        .retired     (retired),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    assign obsW = {DA, SA, SB, W, K, BS, FS, write, selEN};

    function automatic logic [3:0] statusOf(input logic [63:0] v);
        return {v[63], (v == 64'd0), v[1:0]};
    endfunction

    function automatic word_t mkWord(input logic [4:0] da, input logic [4:0] sa,
                                     input logic [4:0] sb, input logic w,
                                     input logic [63:0] k, input logic bs,
                                     input logic [4:0] fs, input logic wr,
                                     input logic sel);
        return '{da: da, sa: sa, sb: sb, w: w, k: k, bs: bs, fs: fs, wr: wr, sel: sel};
    endfunction

    function automatic logic [63:0] archRead(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : archR[a];
    endfunction

    // Combinational half of the datapath stand-in: operand fetch, ALU, bus mux.
    always_comb begin
        aBus      = (SA == 5'd31) ? 64'd0 : regs[SA];
        storeData = (SB == 5'd31) ? 64'd0 : regs[SB];
        bBus      = BS ? K : storeData;
        case (FS)
            FS_OR:   fRes = aBus | bBus;
            FS_ADD:  fRes = aBus + bBus;
            FS_XOR:  fRes = aBus ^ bBus;
            FS_LSL:  fRes = aBus << bBus[5:0];
            default: fRes = 64'd0;
        endcase
        dBus   = selEN ? dpMem[fRes[7:0]] : fRes;
        status = statusOf(fRes);
    end

    // Clocked half of the datapath stand-in: register and memory writes.
    always @(posedge clock) begin
        if (W && DA != 5'd31) regs[DA] <= dBus;
        if (write) dpMem[fRes[7:0]] <= storeData;
    end

    // Runaway guard in case the bench logic ever stalls.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_word"}, 128'(obsW), 128'(mkWord(0, 0, 0, 0, 0, 0, FS_OR, 0, 0)));
        checkOutput({tag, "_ready"}, 128'(instr_ready), 128'(1'b1));
        checkOutput({tag, "_flags"}, 128'(flags), 128'(4'd0));
        checkOutput({tag, "_retired"}, 128'(retired), 128'(16'd0));
        checkOutput({tag, "_done"}, 128'(done), 128'(1'b0));
        checkOutput({tag, "_illegal"}, 128'(illegal), 128'(1'b0));
    endtask

    // Issue one instruction from an IDLE cycle and follow it to completion,
    // comparing every cycle with the expected control word and counters.
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [12:0] imm, input logic holdValid);
        word_t       expExec;
        word_t       expWb;
        logic [63:0] a, b, kk, res;
        logic        writesRd, setsFlags;
        logic [7:0]  addr;
        a         = archRead(rs1);
        b         = archRead(rs2);
        kk        = {51'd0, imm};
        res       = 64'd0;
        writesRd  = 1'b0;
        setsFlags = 1'b0;
        addr      = a[7:0];
        expExec   = mkWord(0, 0, 0, 0, 0, 0, FS_OR, 0, 0);
        expWb     = expExec;
        case (op)
            4'd1: begin expExec = mkWord(rd, 31, 0, 1, kk, 1, FS_OR, 0, 0);  res = kk;       writesRd = 1; setsFlags = 1; end
            4'd2: begin expExec = mkWord(rd, rs1, rs2, 1, 0, 0, FS_ADD, 0, 0); res = a + b;   writesRd = 1; setsFlags = 1; end
            4'd3: begin expExec = mkWord(rd, rs1, rs2, 1, 0, 0, FS_XOR, 0, 0); res = a ^ b;   writesRd = 1; setsFlags = 1; end
            4'd4: begin expExec = mkWord(rd, rs1, 0, 1, kk, 1, FS_LSL, 0, 0); res = a << kk[5:0]; writesRd = 1; setsFlags = 1; end
            4'd5: begin expExec = mkWord(0, rs1, rs2, 0, 0, 1, FS_OR, 1, 0); end
            4'd6: begin
                expExec  = mkWord(0, rs1, 0, 0, 0, 1, FS_OR, 0, 0);
                expWb    = mkWord(rd, rs1, 0, 1, 0, 1, FS_OR, 0, 1);
                res      = archM[addr];
                writesRd = 1;
            end
            4'd7: begin expExec = mkWord(rd, rs1, 0, 1, kk, 1, FS_ADD, 0, 0); res = a + kk; writesRd = 1; setsFlags = 1; end
            default: ;
        endcase

        instr       = {op, rd, rs1, rs2, imm};
        instr_valid = 1'b1;
        checkOutput("ready_before", 128'(instr_ready), 128'(1'b1));
        @(posedge clock); #1;
        if (holdValid) instr = $urandom();
        else instr_valid = 1'b0;
        checkOutput($sformatf("exec_word_op%0d", op), 128'(obsW), 128'(expExec));
        checkOutput("exec_ready", 128'(instr_ready), 128'(1'b0));
        checkOutput("exec_done", 128'(done), 128'(op != 4'd6));
        if (op == 4'd6) begin
            @(posedge clock); #1;
            checkOutput("ldwb_word", 128'(obsW), 128'(expWb));
            checkOutput("ldwb_ready", 128'(instr_ready), 128'(1'b0));
            checkOutput("ldwb_done", 128'(done), 128'(1'b1));
        end

        expRetired = expRetired + 16'd1;
        if (setsFlags) expFlags = statusOf(res);
        if (op[3]) expIllegal = 1'b1;
        if (writesRd && rd != 5'd31) archR[rd] = res;
        if (op == 4'd5) archM[addr] = b;

        @(posedge clock); #1;
        checkOutput("after_word", 128'(obsW), 128'(mkWord(0, 0, 0, 0, 0, 0, FS_OR, 0, 0)));
        checkOutput("after_done", 128'(done), 128'(1'b0));
        checkOutput("after_ready", 128'(instr_ready), 128'(1'b1));
        checkOutput("retired", 128'(retired), 128'(expRetired));
        checkOutput("flags", 128'(flags), 128'(expFlags));
        checkOutput("illegal", 128'(illegal), 128'(expIllegal));
        if (writesRd && rd != 5'd31) checkOutput($sformatf("regfile_r%0d", rd), 128'(regs[rd]), 128'(archR[rd]));
        if (op == 4'd5) checkOutput("memory", 128'(dpMem[addr]), 128'(archM[addr]));
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        #12;
        checkResetState("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Single LDI, then the five-instruction program.
        applyStimulus(4'd1, 5'd5, 5'd0, 5'd0, 13'd24, 1'b0);
        checkOutput("ldi_r5", 128'(regs[5]), 128'(64'd24));
        applyStimulus(4'd1, 5'd7, 5'd0, 5'd0, 13'd39, 1'b0);
        applyStimulus(4'd2, 5'd1, 5'd5, 5'd7, 13'd0, 1'b0);
        applyStimulus(4'd3, 5'd30, 5'd1, 5'd5, 13'd0, 1'b0);
        applyStimulus(4'd4, 5'd17, 5'd30, 5'd0, 13'd2, 1'b0);
        checkOutput("prog_r1", 128'(regs[1]), 128'(64'd63));
        checkOutput("prog_r30", 128'(regs[30]), 128'(64'd39));
        checkOutput("prog_r17", 128'(regs[17]), 128'(64'd156));
        checkOutput("prog_retired", 128'(retired), 128'(16'd5));

        // Store then load through memory.
        applyStimulus(4'd5, 5'd0, 5'd7, 5'd17, 13'd0, 1'b0);
        applyStimulus(4'd6, 5'd0, 5'd7, 5'd0, 13'd0, 1'b0);
        checkOutput("ld_r0", 128'(regs[0]), 128'(64'd156));

        // Valid held through the busy cycle of the previous instruction.
        applyStimulus(4'd7, 5'd9, 5'd5, 5'd0, 13'd100, 1'b1);
        applyStimulus(4'd2, 5'd10, 5'd9, 5'd5, 13'd0, 1'b0);

        // Undefined opcode, then a NOP: illegal must stay set.
        applyStimulus(4'hA, 5'd4, 5'd3, 5'd2, 13'h1FFF, 1'b0);
        applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0);
        checkOutput("illegal_sticky", 128'(illegal), 128'(1'b1));

        // Random instruction stream.
        for (int n = 0; n < 150; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom),
                          5'($urandom), 13'($urandom), 1'($urandom));
        end
        instr_valid = 1'b0;

        // Known operands for the abort tests.
        applyStimulus(4'd1, 5'd7, 5'd0, 5'd0, 13'd200, 1'b0);
        applyStimulus(4'd1, 5'd17, 5'd0, 5'd0, 13'h1ABC, 1'b0);
        applyStimulus(4'd1, 5'd3, 5'd0, 5'd0, 13'd5, 1'b0);

        // Reset in the EXEC cycle of a store.
        instr       = {4'd5, 5'd0, 5'd7, 5'd17, 13'd0};
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        checkOutput("st_exec_write", 128'(write), 128'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        checkResetState("st_abort");
        expRetired = 16'd0;
        expFlags   = 4'd0;
        expIllegal = 1'b0;
        @(posedge clock); #1;
        checkOutput("st_abort_mem", 128'(dpMem[200]), 128'(archM[200]));
        reset = 1'b0;
        @(posedge clock); #1;

        // Reset in the LD_WB cycle of a load.
        instr       = {4'd6, 5'd3, 5'd7, 5'd0, 13'd0};
        instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        checkOutput("ldwb_pre_w", 128'(W), 128'(1'b1));
        checkOutput("ldwb_pre_sel", 128'(selEN), 128'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        checkResetState("ld_abort");
        @(posedge clock); #1;
        checkOutput("ld_abort_r3", 128'(regs[3]), 128'(archR[3]));
        reset = 1'b0;
        @(posedge clock); #1;

        // Counter wrap: preset near the top, then retire two NOPs.
        force dut.retired_q = 16'hFFFE;
        @(posedge clock); #1;
        release dut.retired_q;
        expRetired = 16'hFFFE;
        checkOutput("preset", 128'(retired), 128'(16'hFFFE));
        applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0);
        applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0);
        checkOutput("wrap", 128'(retired), 128'(16'h0000));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as the codebase does: clock and reset.
REQ-002 clock  in  1  rising-edge clock shared with DatapathRegALU.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr  in  32  op[31:28], rd[27:23], rs1[22:18], rs2[17:13], imm[12:0].
REQ-006 status  in  4  ALU status from the datapath.
REQ-007 instr_ready  out  1  sequencer accepts instr this cycle.
REQ-008 DA, SA, SB  out  5 each  destination and source register selects.
REQ-009 W  out  1  register-file write enable.
REQ-010 K  out  64  constant, imm zero-extended.
REQ-011 BS  out  1  B-operand select: 1 = K, 0 = R[SB].
REQ-012 FS  out  5  ALU function select.
REQ-013 write  out  1  memory write enable.
REQ-014 selEN  out  1  data-bus source select: 1 = memory read data, 0 = ALU.
REQ-015 flags  out  4  status captured at last ALU op.
REQ-016 retired  out  16  count of completed instructions.
REQ-017 done  out  1  one-cycle pulse when an instruction completes.
REQ-018 illegal  out  1  sticky flag set by an undefined opcode.

Function
REQ-019 FS codes SHALL be fixed: OR = 00100, ADD = 01000, XOR = 01100, LSL = 10000; register 31 SHALL be treated as zero.
REQ-020 The FSM SHALL have states IDLE, EXEC, LD_WB.
REQ-021 IDLE: instr_ready = 1; on instr_valid & instr_ready, instr SHALL be latched and the FSM SHALL go to EXEC; otherwise it SHALL stay in IDLE.
REQ-022 In every state other than EXEC and LD_WB, outputs SHALL carry the idle word: W = write = selEN = 0; DA = SA = SB = 0; K = 0; BS = 0; FS = 00100.
REQ-023 EXEC SHALL drive the decoded control word for exactly one cycle, then go to IDLE, except LD, which SHALL go to LD_WB.
REQ-024 Op decode:
- 0 NOP: idle word.
- 1 LDI: DA = rd, SA = 31, BS = 1, K = imm, FS = OR, W = 1.
- 2 ADD: DA = rd, SA = rs1, SB = rs2, BS = 0, FS = ADD, W = 1.
- 3 XOR: as ADD with FS = XOR.
- 4 LSLI: DA = rd, SA = rs1, BS = 1, K = imm, FS = LSL, W = 1.
- 5 ST: SA = rs1 (address), SB = rs2 (data), BS = 1, K = 0, FS = OR, W = 0, write = 1, selEN = 0.
- 6 LD, EXEC cycle: SA = rs1, BS = 1, K = 0, FS = OR, W = 0, write = 0.
- 7 ADDI: as LSLI with FS = ADD.
REQ-025 LD_WB SHALL hold SA, BS, K and FS from the LD EXEC cycle and drive selEN = 1, W = 1, DA = rd for one cycle, then go to IDLE.
REQ-026 Opcodes 8-15 SHALL set illegal, drive the idle word in EXEC, and still count as retired.
REQ-027 flags SHALL capture status at the end of EXEC for ops 1, 2, 3, 4 and 7 only.
REQ-028 done SHALL pulse, and retired SHALL increment (wrapping 0xFFFF to 0x0000), on the last cycle of each instruction (EXEC or LD_WB).
REQ-029 Latency: 2 cycles accept-to-complete; 3 cycles for LD. Issue rate: at most one instruction per 2 cycles.
REQ-030 instr SHALL be ignored while instr_ready = 0; a valid held through busy cycles SHALL be accepted on the next IDLE cycle.

Reset
REQ-031 Asserting reset SHALL immediately, without waiting for a clock edge, return the FSM to IDLE.
REQ-032 On reset: idle word on the control outputs, instr_ready = 1, flags = 0, retired = 0, done = 0, illegal = 0.
REQ-033 Reset during EXEC or LD_WB SHALL abort the instruction with no W or write pulse and no retire.

Verification
REQ-034 LDI rd = 5, imm = 24 -> EXEC: DA = 5, SA = 31, K = 24, BS = 1, FS = 00100, W = 1; done pulses; retired = 1.
REQ-035 Program "LDI R5,24; LDI R7,39; ADD R1,R5,R7; XOR R30,R1,R5; LSLI R17,R30,2" against DatapathRegALU -> R1 = 63, R30 = 39, R17 = 156; retired = 5.
REQ-036 ST rs1 = 7, rs2 = 17, then LD rd = 0, rs1 = 7 -> write = 1 for one cycle; LD_WB has selEN = 1, W = 1, DA = 0; R0 = 156; LD done occurs 3 cycles after accept.
REQ-037 Opcode 0xA -> illegal = 1 and stays set; no W or write asserted; retired increments.
REQ-038 Reset asserted mid-LD_WB -> outputs return to the idle word within the same cycle; retired unchanged; instr_ready = 1.
REQ-039 retired preset to 0xFFFF via 65535 NOPs, then one more NOP -> retired = 0x0000, done pulses.
